// File: rtl/bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// bram_fifo_ctrl
//   Stream FIFO controller in front of an external simple dual-port BRAM with
//   one cycle of read latency. Words accepted on the s_* side are written
//   straight into the BRAM. Reads are issued ahead of demand into a two-entry
//   output buffer, so that m_* can deliver one word per cycle.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   s_valid/s_ready : upstream handshake, s_data is the upstream word
//   m_valid/m_ready : downstream handshake, m_data is the oldest buffered word
//   count           : words held (BRAM + read in flight + output buffer)
//   bram_we/bram_wr_addr/bram_wr_data : BRAM write port
//   bram_rd_addr    : BRAM read address, sampled by the BRAM every edge
//   bram_rd_data    : BRAM read data, valid the cycle after the sampling edge
// -----------------------------------------------------------------------------
module bram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [DATA_WIDTH-1:0] bram_rd_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            out_occ_q, out_occ_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;   // oldest entry
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

    logic       push;
    logic       pop;
    logic       rd_issue;
    logic [2:0] pending;
    logic [1:0] occ_after_pop;

    // Handshakes and read issue
    always_comb begin
        s_ready  = (mem_count_q != DEPTH_C);
        push     = s_valid & s_ready & ~rst;
        m_valid  = (out_occ_q != 2'd0);
        pop      = m_valid & m_ready;
        // Buffer slots already spoken for after this cycle's pop; a new read
        // may only be issued if it is guaranteed a slot when its data lands.
        pending  = {1'b0, out_occ_q} + {2'b00, inflight_q};
        rd_issue = (mem_count_q != '0) & (pending < (3'd2 + {2'b00, pop}));
    end

    always_comb begin
        bram_we      = push;
        bram_wr_addr = wr_ptr_q;
        bram_wr_data = s_data;
        bram_rd_addr = rd_ptr_q;
        // Empty buffer presents zero rather than stale data.
        m_data       = m_valid ? buf0_q : '0;
        count        = (ADDR_WIDTH+2)'(mem_count_q)
                     + (ADDR_WIDTH+2)'(inflight_q)
                     + (ADDR_WIDTH+2)'(out_occ_q);
    end

    // Next-state
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_count_d = mem_count_q;
        inflight_d  = rd_issue;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        mem_count_d = mem_count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(rd_issue);

        // Shift on pop first, then append the landing read word behind
        // whatever remains so FIFO order is preserved.
        occ_after_pop = out_occ_q - {1'b0, pop};
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if (occ_after_pop == 2'd0) begin
                buf0_d = bram_rd_data;
            end else begin
                buf1_d = bram_rd_data;
            end
        end
        out_occ_d = occ_after_pop + {1'b0, inflight_q};
    end

    // Control state, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            inflight_q  <= 1'b0;
            out_occ_q   <= 2'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            inflight_q  <= inflight_d;
            out_occ_q   <= out_occ_d;
        end
    end

    // Buffer data, qualified by out_occ_q so it needs no reset
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

endmodule
